// File: rtl/dual_mult_add_pkg.sv
// -----------------------------------------------------------------------------
// dual_mult_add_pkg
// Shared definitions for the two-term multiply-add block:
//   - OP_ADD / OP_SUB : operation select encoding (0 = add, 1 = subtract)
//   - psize_f         : result width for given operand widths
//   - latency_f       : total register latency for a set of stage enables
// -----------------------------------------------------------------------------
package dual_mult_add_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    // Full-precision width of a0*b0 +/- a1*b1: both products plus one carry bit.
    function automatic int psize_f(input int asize, input int bsize);
        return asize + bsize + 1;
    endfunction

    function automatic int latency_f(input int inreg_en, input int pipe_en_1,
                                     input int pipe_en_2, input int pipe_en_3,
                                     input int outreg_en);
        return inreg_en + pipe_en_1 + pipe_en_2 + pipe_en_3 + outreg_en;
    endfunction

endpackage

// File: rtl/dual_mult_add_pipe_reg.sv
// -----------------------------------------------------------------------------
// multadd_pipe_reg
// One optional pipeline stage of dual_mult_add.
//   EN != 0 : register with asynchronous active-low clear and clock-enable hold
//   EN == 0 : wire pass-through (q = d), clock/reset/ce unused
// Ports:
//   clk   in  1      clock, rising edge
//   rst_n in  1      asynchronous active-low clear
//   ce    in  1      clock enable (hold when low)
//   d     in  WIDTH  stage input
//   q     out WIDTH  stage output
// -----------------------------------------------------------------------------
module multadd_pipe_reg #(
    parameter int WIDTH = 1,
    parameter int EN    = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    if (EN != 0) begin : g_reg
        logic [WIDTH-1:0] q_r;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                q_r <= '0;
            end else if (ce) begin
                q_r <= d;
            end
        end

        assign q = q_r;
    end else begin : g_bypass
        // Stage disabled: control inputs are intentionally left unconnected.
        logic unused_ctrl;
        assign unused_ctrl = ^{clk, rst_n, ce};
        assign q = d;
    end

endmodule

// File: rtl/dual_mult_add.sv
// -----------------------------------------------------------------------------
// dual_mult_add
// Pipelined two-term multiply-add: p = a0*b0 + a1*b1  (or a0*b0 - a1*b1).
// Result is PSIZE = ASIZE+BSIZE+1 bits, modulo 2^PSIZE.
// Latency = INREG_EN + PIPEREG_EN_1 + PIPEREG_EN_2 + PIPEREG_EN_3 + OUTREG_EN.
//
// Build option: define MULTADD_DYN_ADDSUB_EN to add the 'addsub' port
// (0 = add, 1 = subtract), carried down the pipeline alongside its operands;
// ADDSUB_OP is then ignored. Without it ADDSUB_OP selects the operation.
//
// Ports:
//   clk    in  1      clock, rising edge
//   rst_n  in  1      asynchronous active-low reset (clears every stage)
//   ce     in  1      clock enable for all stages
//   addsub in  1      dynamic add/subtract (MULTADD_DYN_ADDSUB_EN only)
//   a0,a1  in  ASIZE  a operands
//   b0,b1  in  BSIZE  b operands
//   p      out PSIZE  result
// -----------------------------------------------------------------------------
module dual_mult_add
    import dual_mult_add_pkg::*;
#(
    parameter int ASIZE        = 8,
    parameter int BSIZE        = 8,
    parameter int A_SIGNED     = 0,
    parameter int B_SIGNED     = 0,
    parameter int INREG_EN     = 0,
    parameter int PIPEREG_EN_1 = 1,
    parameter int PIPEREG_EN_2 = 1,
    parameter int PIPEREG_EN_3 = 1,
    parameter int OUTREG_EN    = 0,
    parameter int ADDSUB_OP    = 0,
    localparam int PSIZE       = psize_f(ASIZE, BSIZE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
`ifdef MULTADD_DYN_ADDSUB_EN
    input  logic             addsub,
`endif
    input  logic [ASIZE-1:0] a0,
    input  logic [ASIZE-1:0] a1,
    input  logic [BSIZE-1:0] b0,
    input  logic [BSIZE-1:0] b1,
    output logic [PSIZE-1:0] p
);

    localparam int IN_W = 1 + 2 * ASIZE + 2 * BSIZE;
    localparam int S1_W = 1 + 2 * PSIZE;

    // Widen each operand to the result width by its own signedness. The
    // products are then taken at PSIZE bits, which yields the exact result
    // modulo 2^PSIZE for every signed/unsigned combination.
    function automatic logic signed [PSIZE-1:0] ext_a(input logic [ASIZE-1:0] v);
        if (A_SIGNED != 0) return $signed({{(PSIZE-ASIZE){v[ASIZE-1]}}, v});
        else               return $signed({{(PSIZE-ASIZE){1'b0}}, v});
    endfunction

    function automatic logic signed [PSIZE-1:0] ext_b(input logic [BSIZE-1:0] v);
        if (B_SIGNED != 0) return $signed({{(PSIZE-BSIZE){v[BSIZE-1]}}, v});
        else               return $signed({{(PSIZE-BSIZE){1'b0}}, v});
    endfunction

    logic op_in;
`ifdef MULTADD_DYN_ADDSUB_EN
    assign op_in = addsub;
`else
    assign op_in = (ADDSUB_OP != 0) ? OP_SUB : OP_ADD;
`endif

    // ---- stage 0: optional input register (operands + operation) ----
    logic [IN_W-1:0]  in_d, opnd_p0;
    logic             op_p0;
    logic [ASIZE-1:0] a0_p0, a1_p0;
    logic [BSIZE-1:0] b0_p0, b1_p0;

    assign in_d = {op_in, a0, a1, b0, b1};

    multadd_pipe_reg #(.WIDTH(IN_W), .EN(INREG_EN)) u_inreg (
        .clk(clk), .rst_n(rst_n), .ce(ce), .d(in_d), .q(opnd_p0)
    );

    assign {op_p0, a0_p0, a1_p0, b0_p0, b1_p0} = opnd_p0;

    logic signed [PSIZE-1:0] prod0_p0, prod1_p0;
    assign prod0_p0 = ext_a(a0_p0) * ext_b(b0_p0);
    assign prod1_p0 = ext_a(a1_p0) * ext_b(b1_p0);

    // ---- stage 1: products registered ----
    logic [S1_W-1:0]         s1_q;
    logic                    op_p1;
    logic signed [PSIZE-1:0] prod0_p1, prod1_p1;

    multadd_pipe_reg #(.WIDTH(S1_W), .EN(PIPEREG_EN_1)) u_stage1 (
        .clk(clk), .rst_n(rst_n), .ce(ce),
        .d({op_p0, prod0_p0, prod1_p0}), .q(s1_q)
    );

    assign {op_p1, prod0_p1, prod1_p1} = s1_q;

    logic signed [PSIZE-1:0] sum_p1;
    assign sum_p1 = (op_p1 == OP_SUB) ? (prod0_p1 - prod1_p1) : (prod0_p1 + prod1_p1);

    // ---- stage 2: sum registered ----
    logic [PSIZE-1:0] sum_p2;

    multadd_pipe_reg #(.WIDTH(PSIZE), .EN(PIPEREG_EN_2)) u_stage2 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .d(sum_p1), .q(sum_p2)
    );

    // ---- stage 3: extra pipeline register ----
    logic [PSIZE-1:0] sum_p3;

    multadd_pipe_reg #(.WIDTH(PSIZE), .EN(PIPEREG_EN_3)) u_stage3 (
        .clk(clk), .rst_n(rst_n), .ce(ce), .d(sum_p2), .q(sum_p3)
    );

    // ---- stage 4: optional output register ----
    logic [PSIZE-1:0] sum_p4;

    multadd_pipe_reg #(.WIDTH(PSIZE), .EN(OUTREG_EN)) u_outreg (
        .clk(clk), .rst_n(rst_n), .ce(ce), .d(sum_p3), .q(sum_p4)
    );

    assign p = sum_p4;

endmodule

// File: tb/tb_dual_mult_add.sv
// -----------------------------------------------------------------------------
// tb_dual_mult_add
// Drives six dual_mult_add configurations from shared stimulus:
//   0: defaults (unsigned, add, L=3)   1: ADDSUB_OP=1 (L=3)
//   2: signed a/b (L=3)                3: L=0
//   4: L=1                             5: L=5
// Expected outputs come from an integer golden model through a per-DUT
// scoreboard queue, plus a table of hand-computed vectors.
// -----------------------------------------------------------------------------
module tb_dual_mult_add;
    import dual_mult_add_pkg::*;

    localparam int ND = 6;
    localparam int ASG   [ND] = '{0, 0, 1, 0, 0, 0};
    localparam int BSG   [ND] = '{0, 0, 1, 0, 0, 0};
    localparam int SUBOP [ND] = '{0, 1, 0, 0, 0, 0};
    localparam int INR   [ND] = '{0, 0, 0, 0, 0, 1};
    localparam int PE1   [ND] = '{1, 1, 1, 0, 1, 1};
    localparam int PE2   [ND] = '{1, 1, 1, 0, 0, 1};
    localparam int PE3   [ND] = '{1, 1, 1, 0, 0, 1};
    localparam int OUTR  [ND] = '{0, 0, 0, 0, 0, 1};

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        ce    = 1'b1;
`ifdef MULTADD_DYN_ADDSUB_EN
    logic        addsub = 1'b0;
`endif
    logic [7:0]  a0 = '0, a1 = '0, b0 = '0, b1 = '0;
    logic [16:0] p_out [ND];

    typedef logic [16:0] exp_q_t [$];
    exp_q_t sb [ND];

    int nchk = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        dual_mult_add #(
            .ASIZE(8), .BSIZE(8),
            .A_SIGNED(ASG[g]), .B_SIGNED(BSG[g]),
            .INREG_EN(INR[g]), .PIPEREG_EN_1(PE1[g]),
            .PIPEREG_EN_2(PE2[g]), .PIPEREG_EN_3(PE3[g]),
            .OUTREG_EN(OUTR[g]), .ADDSUB_OP(SUBOP[g])
        ) u_dut (
            .clk(clk),
            .rst_n(rst_n),
            .ce(ce),
`ifdef MULTADD_DYN_ADDSUB_EN
            .addsub(addsub),
`endif
            .a0(a0),
            .a1(a1),
            .b0(b0),
            .b1(b1),
            .p(p_out[g])
        );
    end

    function automatic int lat_of(input int d);
        return latency_f(INR[d], PE1[d], PE2[d], PE3[d], OUTR[d]);
    endfunction

    function automatic logic eff_sub(input int d);
`ifdef MULTADD_DYN_ADDSUB_EN
        return addsub;
`else
        return SUBOP[d] != 0;
`endif
    endfunction

    // Golden model: plain 64-bit integer arithmetic, truncated to 17 bits.
    function automatic logic [16:0] model(input int d, input logic [7:0] xa0, xb0,
                                          xa1, xb1, input logic sub);
        longint ea0, eb0, ea1, eb1, r;
        ea0 = (ASG[d] != 0) ? longint'($signed(xa0)) : longint'(xa0);
        ea1 = (ASG[d] != 0) ? longint'($signed(xa1)) : longint'(xa1);
        eb0 = (BSG[d] != 0) ? longint'($signed(xb0)) : longint'(xb0);
        eb1 = (BSG[d] != 0) ? longint'($signed(xb1)) : longint'(xb1);
        r = sub ? (ea0 * eb0 - ea1 * eb1) : (ea0 * eb0 + ea1 * eb1);
        return r[16:0];
    endfunction

    // Scoreboard: each queue mirrors one DUT's pipeline, front = value on p.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int d = 0; d < ND; d++) begin
                sb[d].delete();
                for (int k = 0; k < lat_of(d); k++) sb[d].push_back('0);
            end
        end else if (ce) begin
            for (int d = 0; d < ND; d++) begin
                if (lat_of(d) > 0) begin
                    sb[d].push_back(model(d, a0, b0, a1, b1, eff_sub(d)));
                    void'(sb[d].pop_front());
                end
            end
        end
    end

    function automatic logic [16:0] expected(input int d);
        if (lat_of(d) == 0) return model(d, a0, b0, a1, b1, eff_sub(d));
        if (sb[d].size() == 0) return 'x;
        return sb[d][0];
    endfunction

    task automatic check_val(input string name, input int d,
                             input logic [16:0] act, input logic [16:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s dut%0d: p=0x%05h expected 0x%05h", name, d, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int d = 0; d < ND; d++) check_val(tag, d, p_out[d], expected(d));
    endtask

    task automatic step(input string tag);
        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    typedef struct {
        logic [7:0]  a0, b0, a1, b1;
        logic [16:0] e_add, e_sub, e_sgn;
    } vec_t;
    vec_t tbl [5];

    task automatic run_row(input int i, input logic as);
        logic [16:0] e_dyn;
        a0 = tbl[i].a0; b0 = tbl[i].b0; a1 = tbl[i].a1; b1 = tbl[i].b1;
`ifdef MULTADD_DYN_ADDSUB_EN
        addsub = as;
`endif
        repeat (3) step("table_pipe");
        e_dyn = as ? tbl[i].e_sub : tbl[i].e_add;
`ifdef MULTADD_DYN_ADDSUB_EN
        check_val("table_dyn", 0, p_out[0], e_dyn);
        check_val("table_dyn", 1, p_out[1], e_dyn);
        if (!as) check_val("table_sgn", 2, p_out[2], tbl[i].e_sgn);
`else
        check_val("table_add", 0, p_out[0], e_dyn);
        check_val("table_sub", 1, p_out[1], tbl[i].e_sub);
        check_val("table_sgn", 2, p_out[2], tbl[i].e_sgn);
`endif
    endtask

    initial begin
        tbl[0] = '{a0: 8'd3,   b0: 8'd5,   a1: 8'd7,   b1: 8'd11,
                   e_add: 17'h0005C, e_sub: 17'h1FFC2, e_sgn: 17'h0005C};
        tbl[1] = '{a0: 8'hFF,  b0: 8'hFF,  a1: 8'hFF,  b1: 8'hFF,
                   e_add: 17'h1FC02, e_sub: 17'h00000, e_sgn: 17'h00002};
        tbl[2] = '{a0: 8'd0,   b0: 8'd0,   a1: 8'd1,   b1: 8'd1,
                   e_add: 17'h00001, e_sub: 17'h1FFFF, e_sgn: 17'h00001};
        tbl[3] = '{a0: 8'hFF,  b0: 8'd2,   a1: 8'h80,  b1: 8'h80,
                   e_add: 17'h041FE, e_sub: 17'h1C1FE, e_sgn: 17'h03FFE};
        tbl[4] = '{a0: 8'd10,  b0: 8'd10,  a1: 8'd3,   b1: 8'd3,
                   e_add: 17'h0006D, e_sub: 17'h0005B, e_sgn: 17'h0006D};

        // Power-on reset, asserted between clock edges.
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < ND; d++)
            if (lat_of(d) > 0) check_val("reset_async", d, p_out[d], 17'h0);
        @(negedge clk);
        check_all("in_reset");
        rst_n = 1'b1;

        // Hand-computed vectors.
        for (int i = 0; i < 5; i++) begin
`ifdef MULTADD_DYN_ADDSUB_EN
            run_row(i, 1'b0);
            run_row(i, 1'b1);
`else
            run_row(i, 1'b0);
`endif
        end

        // Back-to-back random stream with a 4-cycle ce stall in the middle.
        for (int n = 0; n < 60; n++) begin
            a0 = 8'($urandom); a1 = 8'($urandom);
            b0 = 8'($urandom); b1 = 8'($urandom);
`ifdef MULTADD_DYN_ADDSUB_EN
            addsub = 1'($urandom);
`endif
            ce = !(n >= 20 && n < 24);
            step(ce ? "stream" : "ce_hold");
        end
        ce = 1'b1;

        // Mid-stream asynchronous reset discards in-flight data.
        a0 = 8'd200; b0 = 8'd201; a1 = 8'd17; b1 = 8'd99;
        #2 rst_n = 1'b0;
        #1;
        for (int d = 0; d < ND; d++)
            if (lat_of(d) > 0) check_val("reset_mid", d, p_out[d], 17'h0);
        @(negedge clk);
        check_all("reset_hold");
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            a0 = 8'($urandom); a1 = 8'($urandom);
            b0 = 8'($urandom); b1 = 8'($urandom);
`ifdef MULTADD_DYN_ADDSUB_EN
            addsub = 1'($urandom);
`endif
            step("after_reset");
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
